key_capture4: RTL and testbench

Upstream capture stage for the 4-to-2 encoder. It takes four raw, asynchronous, bouncy key/request lines and synchronizes and debounces each one. It turns each debounced rising edge into a clean one-hot request on `onehot_out`, which feeds the encoder's 4-bit `in` directly. Each request is held stable until the consumer acknowledges it, so the encoder always sees a legal one-hot (or all-zero) code.

---
 rtl/key_capture4.sv | 142 ++++++++++++++
 tb/tb_key_capture4.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/key_capture4.sv
// key_capture4: capture stage in front of the 4-to-2 encoder.
//
// Each of four raw, asynchronous, bouncy key lines is synchronized through two
// flops and then debounced. The design turns each debounced rising edge into a
// one-cycle rise event. A small IDLE/HOLD FSM converts rise events into a held
// one-hot request that stays stable until the consumer acknowledges it.
//
// Ports:
//   clk         - single clock, all state updates on its rising edge
//   rst         - synchronous, active-high reset
//   key_in[3:0] - raw asynchronous key/request lines, active-high
//   ack         - consumer has taken the current request
//   onehot_out  - registered one-hot request, 0000 when idle
//   valid       - registered, high while onehot_out holds a request
//   missed      - registered sticky flag, set when a rise event is dropped
//
// Parameter:
//   DEBOUNCE_CYCLES - consecutive cycles a synchronized level must differ
//                     from the debounced level before that level flips (>= 1)
module key_capture4 #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] key_in,
    input  logic       ack,
    output logic [3:0] onehot_out,
    output logic       valid,
    output logic       missed
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    logic [3:0]    s1_q;
    logic [3:0]    s2_q;
    logic [3:0]    db_q;
    logic [3:0]    db_d;
    logic [3:0]    dbPrev_q;
    logic [CW-1:0] cnt_q [4];
    logic [CW-1:0] cnt_d [4];
    logic [3:0]    rise_q;
    logic [3:0]    riseLowest;
    state_t        state_q;
    logic [3:0]    onehot_q;
    logic          valid_q;
    logic          missed_q;

    // Per-bit debounce: the counter only advances while the synchronized level
    // disagrees with the debounced level, and any agreement restarts it.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            db_d[i]  = db_q[i];
            cnt_d[i] = '0;
            if (s2_q[i] != db_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    db_d[i] = s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Two-flop synchronizer, debounce state, and rise detection. The rise event
    // compares the debounced level with its own delayed copy, so it appears one
    // edge after db flips to 1 and lasts exactly one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q     <= '0;
            s2_q     <= '0;
            db_q     <= '0;
            dbPrev_q <= '0;
            rise_q   <= '0;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            s1_q     <= key_in;
            s2_q     <= s1_q;
            db_q     <= db_d;
            dbPrev_q <= db_q;
            rise_q   <= db_q & ~dbPrev_q;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Isolate the lowest-index set rise bit (two's-complement trick).
    assign riseLowest = rise_q & (~rise_q + 4'd1);

    // Request FSM with registered outputs. In HOLD an ack clears the request
    // and the sticky missed flag first; a rise in the same cycle is then
    // recorded as a drop, so missed ends up set and nothing new is captured.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            onehot_q <= '0;
            valid_q  <= 1'b0;
            missed_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|rise_q) begin
                        onehot_q <= riseLowest;
                        valid_q  <= 1'b1;
                        state_q  <= HOLD;
                        if (|(rise_q & ~riseLowest)) begin
                            missed_q <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (ack) begin
                        onehot_q <= '0;
                        valid_q  <= 1'b0;
                        missed_q <= |rise_q;
                        state_q  <= IDLE;
                    end else if (|rise_q) begin
                        missed_q <= 1'b1;
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    onehot_q <= '0;
                    valid_q  <= 1'b0;
                end
            endcase
        end
    end

    assign onehot_out = onehot_q;
    assign valid      = valid_q;
    assign missed     = missed_q;

endmodule

// File: tb/tb_key_capture4.sv
// tb_key_capture4: directed bench for key_capture4 with DEBOUNCE_CYCLES = 4.
// Inputs change 1 time unit after a rising edge, so the next rising edge is
// "edge 1" of a scenario; outputs are sampled 1 time unit after each edge.
// Expected values are written as {onehot_out, valid, missed}.
module tb_key_capture4;

    logic       clk;
    logic       rst;
    logic [3:0] key_in;
    logic       ack;
    logic [3:0] onehot_out;
    logic       valid;
    logic       missed;

    int passCount;
    int checkCount;

    key_capture4 #(
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .key_in    (key_in),
        .ack       (ack),
        .onehot_out(onehot_out),
        .valid     (valid),
        .missed    (missed)
    );

    // 10-unit clock period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges, landing 1 unit after the last one.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        checkCount++;
        if ({onehot_out, valid, missed} !== 6'b0000_0_0)
            $display("[TB] FAIL reset_state: got %b%b%b expected 000000", onehot_out, valid, missed);
        else
            passCount++;
    endtask

    task automatic test_clean_press();
        key_in = 4'b0001;
        tick(7);
        checkCount++;
        if ({onehot_out, valid, missed} !== 6'b0000_0_0)
            $display("[TB] FAIL clean_edge7: got %b%b%b expected 000000", onehot_out, valid, missed);
        else
            passCount++;
        tick(1);
        checkCount++;
        if ({onehot_out, valid, missed} !== 6'b0001_1_0)
            $display("[TB] FAIL clean_edge8: got %b%b%b expected 000110", onehot_out, valid, missed);
        else
            passCount++;
        tick(3);
        checkCount++;
        if ({onehot_out, valid, missed} !== 6'b0001_1_0)
            $display("[TB] FAIL clean_held: got %b%b%b expected 000110", onehot_out, valid, missed);
        else
            passCount++;
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
        checkCount++;
        if ({onehot_out, valid, missed} !== 6'b0000_0_0)
            $display("[TB] FAIL clean_ack: got %b%b%b expected 000000", onehot_out, valid, missed);
        else
            passCount++;
        // Key still held: no second event may appear.
        tick(6);
        checkCount++;
        if ({onehot_out, valid, missed} !== 6'b0000_0_0)
            $display("[TB] FAIL clean_no_repeat: got %b%b%b expected 000000", onehot_out, valid, missed);
        else
            passCount++;
        key_in = 4'b0000;
        tick(10);
    endtask

    task automatic test_glitch();
        key_in = 4'b0100;
        tick(3);
        key_in = 4'b0000;
        tick(12);
        checkCount++;
        if ({onehot_out, valid, missed} !== 6'b0000_0_0)
            $display("[TB] FAIL glitch_rejected: got %b%b%b expected 000000", onehot_out, valid, missed);
        else
            passCount++;
    endtask

    task automatic test_simultaneous();
        key_in = 4'b0110;
        tick(7);
        checkCount++;
        if ({onehot_out, valid, missed} !== 6'b0000_0_0)
            $display("[TB] FAIL simul_edge7: got %b%b%b expected 000000", onehot_out, valid, missed);
        else
            passCount++;
        tick(1);
        checkCount++;
        if ({onehot_out, valid, missed} !== 6'b0010_1_1)
            $display("[TB] FAIL simul_lowest: got %b%b%b expected 001011", onehot_out, valid, missed);
        else
            passCount++;
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
        checkCount++;
        if ({onehot_out, valid, missed} !== 6'b0000_0_0)
            $display("[TB] FAIL simul_ack: got %b%b%b expected 000000", onehot_out, valid, missed);
        else
            passCount++;
        key_in = 4'b0000;
        tick(10);
    endtask

    task automatic test_press_during_hold();
        key_in = 4'b0001;
        tick(8);
        checkCount++;
        if ({onehot_out, valid, missed} !== 6'b0001_1_0)
            $display("[TB] FAIL hold_first: got %b%b%b expected 000110", onehot_out, valid, missed);
        else
            passCount++;
        key_in = 4'b1001;
        tick(8);
        checkCount++;
        if ({onehot_out, valid, missed} !== 6'b0001_1_1)
            $display("[TB] FAIL hold_dropped: got %b%b%b expected 000111", onehot_out, valid, missed);
        else
            passCount++;
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
        checkCount++;
        if ({onehot_out, valid, missed} !== 6'b0000_0_0)
            $display("[TB] FAIL hold_ack: got %b%b%b expected 000000", onehot_out, valid, missed);
        else
            passCount++;
        key_in = 4'b0000;
        tick(10);
    endtask

    task automatic test_ack_with_rise();
        key_in = 4'b0001;
        tick(8);
        checkCount++;
        if ({onehot_out, valid, missed} !== 6'b0001_1_0)
            $display("[TB] FAIL ackrise_hold: got %b%b%b expected 000110", onehot_out, valid, missed);
        else
            passCount++;
        // rise[2] is seen by the FSM at edge 8 of this new press.
        key_in = 4'b0101;
        tick(7);
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
        checkCount++;
        if ({onehot_out, valid, missed} !== 6'b0000_0_1)
            $display("[TB] FAIL ackrise_clear: got %b%b%b expected 000001", onehot_out, valid, missed);
        else
            passCount++;
        tick(3);
        checkCount++;
        if ({onehot_out, valid, missed} !== 6'b0000_0_1)
            $display("[TB] FAIL ackrise_not_captured: got %b%b%b expected 000001", onehot_out, valid, missed);
        else
            passCount++;
        key_in = 4'b0000;
        tick(10);
    endtask

    task automatic test_reset_mid_hold();
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        checkCount++;
        if ({onehot_out, valid, missed} !== 6'b0000_0_0)
            $display("[TB] FAIL rsthold_clear_missed: got %b%b%b expected 000000", onehot_out, valid, missed);
        else
            passCount++;
        key_in = 4'b0001;
        tick(8);
        checkCount++;
        if ({onehot_out, valid, missed} !== 6'b0001_1_0)
            $display("[TB] FAIL rsthold_before: got %b%b%b expected 000110", onehot_out, valid, missed);
        else
            passCount++;
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        checkCount++;
        if ({onehot_out, valid, missed} !== 6'b0000_0_0)
            $display("[TB] FAIL rsthold_cleared: got %b%b%b expected 000000", onehot_out, valid, missed);
        else
            passCount++;
        tick(7);
        checkCount++;
        if ({onehot_out, valid, missed} !== 6'b0000_0_0)
            $display("[TB] FAIL rsthold_edge7: got %b%b%b expected 000000", onehot_out, valid, missed);
        else
            passCount++;
        tick(1);
        checkCount++;
        if ({onehot_out, valid, missed} !== 6'b0001_1_0)
            $display("[TB] FAIL rsthold_edge8: got %b%b%b expected 000110", onehot_out, valid, missed);
        else
            passCount++;
    endtask

    initial begin
        passCount  = 0;
        checkCount = 0;
        rst        = 1'b0;
        key_in     = 4'b0000;
        ack        = 1'b0;
        #1;
        test_reset();
        test_clean_press();
        test_glitch();
        test_simultaneous();
        test_press_during_hold();
        test_ack_with_rise();
        test_reset_mid_hold();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
